// File: rtl/key_event_pkg.sv
// Shared constants and event-code helpers for the push-button front end.
package key_event_pkg;

  localparam int   KEY_NUM      = 4;
  localparam int   EVT_W        = 3;
  localparam logic EVT_PRESS    = 1'b1;
  localparam logic EVT_RELEASE  = 1'b0;
  localparam int   DEB_CNT_DFLT = 1_000_000;
  localparam int   DEB_CNT_W    = 24;

  // Event code layout: {type, key index}
  function automatic logic [EVT_W-1:0] evt_pack(input logic evt_type,
                                                input logic [1:0] key_idx);
    return {evt_type, key_idx};
  endfunction

  function automatic logic evt_type_of(input logic [EVT_W-1:0] code);
    return code[2];
  endfunction

  function automatic logic [1:0] evt_key_of(input logic [EVT_W-1:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/key_event_gen_debounce.sv
// One key channel: two-flop synchroniser, stability counter, clean level and
// registered press/release strobes.
module key_debounce_ch
  import key_event_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DFLT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_stable,
  output logic key_press,
  output logic key_release
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CNT - 1);
  localparam logic [DEB_CNT_W-1:0] CNT_ONE  = DEB_CNT_W'(1);

  logic                 key_meta;
  logic                 key_sync;
  logic [DEB_CNT_W-1:0] deb_cnt;

  // Bring the asynchronous pin into the sys_clk domain (idle level is 1)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  // Accept a new level only after DEB_CNT consecutive disagreeing cycles
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_cnt     <= '0;
      key_stable  <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (key_sync == key_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt     <= '0;
        key_stable  <= key_sync;
        key_press   <= ~key_sync;
        key_release <= key_sync;
      end else begin
        deb_cnt <= deb_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Four-button front end: debounced levels, strobes, and a buffered
// press/release event stream with valid/ready handshake.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int DEB_CNT    = DEB_CNT_DFLT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [3:0]       key,
  output logic [3:0]       key_stable,
  output logic [3:0]       key_press,
  output logic [3:0]       key_release,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVT_W-1:0] evt_code,
  output logic             evt_drop
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          NFLAG   = 2 * KEY_NUM;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [NFLAG-1:0] strb;
  logic [NFLAG-1:0] pend;
  logic [NFLAG-1:0] sel_oh;
  logic [NFLAG-1:0] clr;
  logic [EVT_W-1:0] sel_code;
  logic             sel_found;
  logic             wr_en;
  logic             pop;
  logic             empty;
  logic             full;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [EVT_W-1:0] mem [FIFO_DEPTH];

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch
    key_debounce_ch #(.DEB_CNT(DEB_CNT)) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key         (key[k]),
      .key_stable  (key_stable[k]),
      .key_press   (key_press[k]),
      .key_release (key_release[k])
    );
  end

  // Interleave strobes so flag index = 2*key + (release ? 1 : 0)
  always_comb begin
    strb = '0;
    for (int k = 0; k < KEY_NUM; k++) begin
      strb[2*k]   = key_press[k];
      strb[2*k+1] = key_release[k];
    end
  end

  // Pick the lowest-index pending flag as the next FIFO entry
  always_comb begin
    sel_oh    = '0;
    sel_code  = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NFLAG; i++) begin
      if (pend[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_oh[i] = 1'b1;
        sel_code  = evt_pack(i[0] ? EVT_RELEASE : EVT_PRESS, 2'(i / 2));
      end
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt_valid = ~empty;
  assign pop       = evt_valid && evt_ready;
  assign wr_en     = sel_found && (!full || pop);
  assign clr       = wr_en ? sel_oh : '0;
  assign evt_code  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pending flags; a strobe hitting a flag that is still held is a loss
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend     <= '0;
      evt_drop <= 1'b0;
    end else begin
      pend     <= (pend & ~clr) | strb;
      evt_drop <= |(strb & pend & ~clr);
    end
  end

  // FIFO pointers with one extra wrap bit for full/empty distinction
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage; contents are only observed through the valid head
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= sel_code;
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with DEB_CNT=8, FIFO_DEPTH=4.
module tb_key_event_gen;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key;
  logic [3:0] key_stable;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;
  logic       evt_drop;

  int n_chk  = 0;
  int n_fail = 0;

  key_event_gen #(.DEB_CNT(8), .FIFO_DEPTH(4)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key         (key),
    .key_stable  (key_stable),
    .key_press   (key_press),
    .key_release (key_release),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_drop    (evt_drop)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] key;
    logic       rdy;
    int         rep;
    logic [3:0] stb;
    logic [3:0] prs;
    logic [3:0] rel;
    logic       vld;
    logic [2:0] code;
    logic       drp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, input logic [3:0] k, input logic rdy,
                     input int rep, input logic [3:0] stb, input logic [3:0] prs,
                     input logic [3:0] rel, input logic vld, input logic [2:0] code,
                     input logic drp);
    vec_t v;
    v.rst_n = rst_n; v.key = k; v.rdy = rdy; v.rep = rep;
    v.stb = stb; v.prs = prs; v.rel = rel; v.vld = vld; v.code = code; v.drp = drp;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      sys_rst_n = tbl[i].rst_n;
      key       = tbl[i].key;
      evt_ready = tbl[i].rdy;
      repeat (tbl[i].rep) tick();
      chk("key_stable",  i, 8'(key_stable),  8'(tbl[i].stb));
      chk("key_press",   i, 8'(key_press),   8'(tbl[i].prs));
      chk("key_release", i, 8'(key_release), 8'(tbl[i].rel));
      chk("evt_valid",   i, 8'(evt_valid),   8'(tbl[i].vld));
      chk("evt_code",    i, 8'(evt_code),    8'(tbl[i].code));
      chk("evt_drop",    i, 8'(evt_drop),    8'(tbl[i].drp));
    end
  endtask

  initial begin
    int a_end, b_end;
    logic seen;

    sys_rst_n = 1'b0;
    key       = 4'hF;
    evt_ready = 1'b0;

    // Reset with keys held pressed, release, all four press simultaneously
    add(0, 4'h0, 1, 3, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'h0, 1, 9, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'hF, 4'h0, 0, 3'd0, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 3'b100, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 3'b101, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 3'b110, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 3'b111, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 0, 3'd0, 0);
    // Mid-operation reset back to released state
    add(0, 4'hF, 1, 2, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'hF, 1, 3, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    a_end = tbl.size();
    // Bounce tail: final falling edge on key1
    add(1, 4'hD, 1, 9, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'hD, 1, 1, 4'hD, 4'h2, 4'h0, 0, 3'd0, 0);
    add(1, 4'hD, 1, 1, 4'hD, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'hD, 1, 1, 4'hD, 4'h0, 4'h0, 1, 3'b101, 0);
    add(1, 4'hD, 1, 1, 4'hD, 4'h0, 4'h0, 0, 3'd0, 0);
    // Key2 press held 20 cycles, then release
    add(1, 4'h9, 1, 10, 4'h9, 4'h4, 4'h0, 0, 3'd0, 0);
    add(1, 4'h9, 1, 2, 4'h9, 4'h0, 4'h0, 1, 3'b110, 0);
    add(1, 4'h9, 1, 1, 4'h9, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'h9, 1, 7, 4'h9, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'hD, 1, 10, 4'hD, 4'h0, 4'h4, 0, 3'd0, 0);
    add(1, 4'hD, 1, 2, 4'hD, 4'h0, 4'h0, 1, 3'b010, 0);
    add(1, 4'hD, 1, 1, 4'hD, 4'h0, 4'h0, 0, 3'd0, 0);
    // Release all, then simultaneous press of all keys
    add(1, 4'hF, 1, 10, 4'hF, 4'h0, 4'h2, 0, 3'd0, 0);
    add(1, 4'hF, 1, 2, 4'hF, 4'h0, 4'h0, 1, 3'b001, 0);
    add(1, 4'hF, 1, 1, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'h0, 1, 10, 4'h0, 4'hF, 4'h0, 0, 3'd0, 0);
    add(1, 4'h0, 1, 2, 4'h0, 4'h0, 4'h0, 1, 3'b100, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 3'b101, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 3'b110, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 3'b111, 0);
    add(1, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 0, 3'd0, 0);
    // Release all with consumer ready: release codes in priority order
    add(1, 4'hF, 1, 10, 4'hF, 4'h0, 4'hF, 0, 3'd0, 0);
    add(1, 4'hF, 1, 2, 4'hF, 4'h0, 4'h0, 1, 3'b000, 0);
    add(1, 4'hF, 1, 1, 4'hF, 4'h0, 4'h0, 1, 3'b001, 0);
    add(1, 4'hF, 1, 1, 4'hF, 4'h0, 4'h0, 1, 3'b010, 0);
    add(1, 4'hF, 1, 1, 4'hF, 4'h0, 4'h0, 1, 3'b011, 0);
    add(1, 4'hF, 1, 1, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    // Consumer stalled: fill FIFO with presses, releases stay pending
    add(1, 4'h0, 0, 10, 4'h0, 4'hF, 4'h0, 0, 3'd0, 0);
    add(1, 4'h0, 0, 2, 4'h0, 4'h0, 4'h0, 1, 3'b100, 0);
    add(1, 4'hF, 0, 12, 4'hF, 4'h0, 4'h0, 1, 3'b100, 0);
    add(1, 4'hE, 0, 10, 4'hE, 4'h1, 4'h0, 1, 3'b100, 0);
    add(1, 4'hE, 0, 1, 4'hE, 4'h0, 4'h0, 1, 3'b100, 0);
    add(1, 4'hF, 0, 10, 4'hF, 4'h0, 4'h1, 1, 3'b100, 0);
    add(1, 4'hF, 0, 1, 4'hF, 4'h0, 4'h0, 1, 3'b100, 1);
    add(1, 4'hF, 0, 1, 4'hF, 4'h0, 4'h0, 1, 3'b100, 0);
    add(1, 4'hE, 0, 10, 4'hE, 4'h1, 4'h0, 1, 3'b100, 0);
    add(1, 4'hE, 0, 1, 4'hE, 4'h0, 4'h0, 1, 3'b100, 1);
    add(1, 4'hE, 0, 1, 4'hE, 4'h0, 4'h0, 1, 3'b100, 0);
    // Consumer resumes: FIFO then pending flags, one per cycle
    add(1, 4'hE, 1, 1, 4'hE, 4'h0, 4'h0, 1, 3'b101, 0);
    add(1, 4'hE, 1, 1, 4'hE, 4'h0, 4'h0, 1, 3'b110, 0);
    add(1, 4'hE, 1, 1, 4'hE, 4'h0, 4'h0, 1, 3'b111, 0);
    add(1, 4'hE, 1, 1, 4'hE, 4'h0, 4'h0, 1, 3'b100, 0);
    add(1, 4'hE, 1, 1, 4'hE, 4'h0, 4'h0, 1, 3'b000, 0);
    add(1, 4'hE, 1, 1, 4'hE, 4'h0, 4'h0, 1, 3'b001, 0);
    add(1, 4'hE, 1, 1, 4'hE, 4'h0, 4'h0, 1, 3'b010, 0);
    add(1, 4'hE, 1, 1, 4'hE, 4'h0, 4'h0, 1, 3'b011, 0);
    add(1, 4'hE, 1, 1, 4'hE, 4'h0, 4'h0, 0, 3'd0, 0);
    // Reset on cycle 5 of counting a key2 press; count restarts afterwards
    add(0, 4'hF, 1, 2, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'hF, 1, 3, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'hB, 1, 7, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(0, 4'hB, 1, 2, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'hB, 1, 9, 4'hF, 4'h0, 4'h0, 0, 3'd0, 0);
    add(1, 4'hB, 1, 1, 4'hB, 4'h4, 4'h0, 0, 3'd0, 0);
    add(1, 4'hB, 1, 2, 4'hB, 4'h0, 4'h0, 1, 3'b110, 0);
    add(1, 4'hB, 1, 1, 4'hB, 4'h0, 4'h0, 0, 3'd0, 0);
    b_end = tbl.size();

    run_rows(0, a_end);

    // key1 bounces every 3 cycles for 42 cycles: nothing may come out
    seen = 1'b0;
    for (int s = 0; s < 14; s++) begin
      key = {2'b11, s[0], 1'b1};
      repeat (3) begin
        tick();
        seen = seen | (|key_press) | (|key_release) | evt_valid;
      end
    end
    chk("bounce_quiet", -1, 8'(seen), 8'd0);
    chk("bounce_stable", -1, 8'(key_stable), 8'hF);

    run_rows(a_end, b_end);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
